// File: rtl/spi_slave_if.sv
// spi_slave_if: TX write port, RX byte port and SPI pins of spi_slave.
// Modports: slave (the SPI slave core), master (host logic + SPI master).
interface spi_slave_if;
    logic [7:0] i_TX_Byte;
    logic       i_TX_Valid;
    logic       o_TX_Ready;
    logic       o_TX_Underrun;
    logic       o_RX_Valid;
    logic [7:0] o_RX_Byte;
    logic       SCLK;
    logic       CS_n;
    logic       MOSI;
    logic       MISO;
    logic       o_MISO_En;

    modport slave (
        input  i_TX_Byte, i_TX_Valid, SCLK, CS_n, MOSI,
        output o_TX_Ready, o_TX_Underrun, o_RX_Valid, o_RX_Byte,
        output MISO, o_MISO_En
    );

    modport master (
        output i_TX_Byte, i_TX_Valid, SCLK, CS_n, MOSI,
        input  o_TX_Ready, o_TX_Underrun, o_RX_Valid, o_RX_Byte,
        input  MISO, o_MISO_En
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave (modes 0-3) with one-byte TX holding register.
// Ports: i_Clk, i_Rst_n (async low), bus = spi_slave_if.slave.
module spi_slave #(
    parameter int         SPI_MODE     = 0,
    parameter logic [7:0] TX_IDLE_BYTE = 8'h00
) (
    input logic        i_Clk,
    input logic        i_Rst_n,
    spi_slave_if.slave bus
);
    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state;

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;
    logic       cs_prev;
    logic [7:0] hold;
    logic       hold_vld;
    logic [7:0] tx_data;
    logic [2:0] tx_cnt;
    logic [2:0] rx_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       undr;
    logic       miso;
    logic       miso_en;

    logic       sclk_s, sclk_p, cs_s, mosi_s;
    logic       lead, trail, smp, shf;
    logic [7:0] next_byte;

    assign sclk_s = sclk_q[1];
    assign sclk_p = sclk_q[2];
    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];

    assign lead  = (sclk_s != CPOL) && (sclk_p == CPOL);
    assign trail = (sclk_s == CPOL) && (sclk_p != CPOL);
    assign smp   = CPHA ? trail : lead;
    assign shf   = CPHA ? lead : trail;

    assign next_byte = hold_vld ? hold : TX_IDLE_BYTE;

    assign bus.o_TX_Ready    = ~hold_vld;
    assign bus.o_TX_Underrun = undr;
    assign bus.o_RX_Valid    = rx_vld;
    assign bus.o_RX_Byte     = rx_byte;
    assign bus.MISO          = miso;
    assign bus.o_MISO_En     = miso_en;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sclk_q   <= {3{CPOL}};
            cs_q     <= 2'b11;
            mosi_q   <= 2'b00;
            cs_prev  <= 1'b1;
            state    <= IDLE;
            hold     <= 8'h00;
            hold_vld <= 1'b0;
            tx_data  <= 8'h00;
            tx_cnt   <= 3'd7;
            rx_cnt   <= 3'd7;
            rx_sr    <= 7'h00;
            rx_byte  <= 8'h00;
            rx_vld   <= 1'b0;
            undr     <= 1'b0;
            miso     <= 1'b0;
            miso_en  <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], bus.SCLK};
            cs_q    <= {cs_q[0], bus.CS_n};
            mosi_q  <= {mosi_q[0], bus.MOSI};
            cs_prev <= cs_s;
            miso_en <= ~cs_s;
            rx_vld  <= 1'b0;
            undr    <= 1'b0;

            if (cs_s) begin
                state  <= IDLE;
                miso   <= 1'b0;
                tx_cnt <= 3'd7;
                rx_cnt <= 3'd7;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_prev)
                            state <= LOAD;
                    end
                    LOAD: begin
                        tx_data  <= next_byte;
                        undr     <= ~hold_vld;
                        hold_vld <= 1'b0;
                        tx_cnt   <= 3'd7;
                        if (!CPHA)
                            miso <= next_byte[7];
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (smp) begin
                            rx_sr  <= {rx_sr[5:0], mosi_s};
                            rx_cnt <= rx_cnt - 3'd1;
                            if (rx_cnt == 3'd0) begin
                                rx_byte <= {rx_sr, mosi_s};
                                rx_vld  <= 1'b1;
                                state   <= LOAD;
                            end
                        end
                        // CPHA=0: bit 7 went out at LOAD; the trailing edge
                        // ending the previous byte (rx_cnt back at 7) is skipped.
                        if (shf) begin
                            if (CPHA) begin
                                miso   <= tx_data[tx_cnt];
                                tx_cnt <= tx_cnt - 3'd1;
                            end else if (rx_cnt != 3'd7) begin
                                miso <= tx_data[rx_cnt];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A write in the LOAD cycle can only land when holding was empty.
            if (bus.i_TX_Valid && !hold_vld) begin
                hold     <= bus.i_TX_Byte;
                hold_vld <= 1'b1;
            end
        end
    end
endmodule
